// File: rtl/mux16_arb_pkg.sv
// Shared constants, state encoding and one-hot helper for the 16-way round-robin
// select arbiter.
package mux16_arb_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;
    localparam int CNT_W   = 8;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_GRANT = 1'b1;

    function automatic logic [0:NUM_REQ-1] onehot_sel(input logic [0:SEL_W-1] idx);
        logic [0:NUM_REQ-1] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotate-priority picker: first set request at or after ptr,
// wrapping modulo 16.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [0:NUM_REQ-1] req,
    input  logic [0:SEL_W-1]   ptr,
    output logic [0:SEL_W-1]   idx,
    output logic               any
);

    logic [0:SEL_W-1] pos;

    // Scan from the far end back toward ptr so the closest hit is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner of the sizteen_one_mux select. Defining MUX16_ARB_LOCK_EN
// adds a lock input that suppresses the hold-limit timeout.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [0:NUM_REQ-1] req,
`ifdef MUX16_ARB_LOCK_EN
    input  logic               lock,
`endif
    output logic [0:SEL_W-1]   sel,
    output logic [0:NUM_REQ-1] gnt,
    output logic               busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t         state_q, state_d;
    logic [0:SEL_W-1]   sel_q, sel_d;
    logic [0:NUM_REQ-1] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [0:SEL_W-1]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [0:SEL_W-1]   pick_ptr;
    logic [0:SEL_W-1]   pick_idx;
    logic               pick_any;
    logic               own_req;
    logic               at_limit;
    logic               hold_ext;
    logic               release_own;

    // While granting, the picker always looks from just past the owner, which is
    // exactly the pointer a release installs; in IDLE it uses the stored pointer.
    assign pick_ptr = (state_q == ST_GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pick16 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign own_req  = req[sel_q];
    assign at_limit = (cnt_q == HOLD_LAST);

`ifdef MUX16_ARB_LOCK_EN
    assign hold_ext = lock && own_req;
`else
    assign hold_ext = 1'b0;
`endif

    assign release_own = !own_req || (at_limit && !hold_ext);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        if (state_q == ST_IDLE) begin
            if (pick_any) begin
                state_d = ST_GRANT;
                sel_d   = pick_idx;
                gnt_d   = onehot_sel(pick_idx);
                busy_d  = 1'b1;
                cnt_d   = '0;
            end
        end else begin
            if (!release_own) begin
                // Only a locked owner can sit at the limit without releasing.
                cnt_d = at_limit ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                ptr_d = sel_q + SEL_W'(1);
                if (pick_any) begin
                    sel_d = pick_idx;
                    gnt_d = onehot_sel(pick_idx);
                    cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: two instances (MAX_HOLD=8 and 2) share
// one request stream and are checked against a rule-level reference model.
module tb_mux16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:15] req;

    logic [0:3]  sel8, sel2;
    logic [0:15] gnt8, gnt2;
    logic        busy8, busy2;

`ifdef MUX16_ARB_LOCK_EN
    logic lock = 1'b0;
`endif

    always #5 clk = ~clk;

    mux16_rr_arbiter #(.MAX_HOLD(8)) u_dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
`ifdef MUX16_ARB_LOCK_EN
        .lock (lock),
`endif
        .sel  (sel8),
        .gnt  (gnt8),
        .busy (busy8)
    );

    mux16_rr_arbiter #(.MAX_HOLD(2)) u_dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
`ifdef MUX16_ARB_LOCK_EN
        .lock (lock),
`endif
        .sel  (sel2),
        .gnt  (gnt2),
        .busy (busy2)
    );

    typedef struct packed {
        logic [0:3]  sel;
        logic [0:15] gnt;
        logic        busy;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: owner index (-1 when idle), cycles held so far, rotation start.
    int m_owner[2];
    int m_held[2];
    int m_ptr[2];
    int m_last[2];
    int mh[2] = '{8, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int find_win(input logic [0:15] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_owner[j] = -1;
            m_held[j]  = 0;
            m_ptr[j]   = 0;
            m_last[j]  = 0;
        end
    endtask

    task automatic model_step(input int j, input logic [0:15] r, output exp_t e);
        int w;
        int s;
        if (m_owner[j] < 0) begin
            w = find_win(r, m_ptr[j]);
            if (w >= 0) begin
                m_owner[j] = w;
                m_held[j]  = 1;
            end
        end else if (r[m_owner[j]] && m_held[j] < mh[j]) begin
            m_held[j]++;
        end else begin
            m_ptr[j] = (m_owner[j] + 1) % 16;
            w = find_win(r, m_ptr[j]);
            if (w >= 0) begin
                m_owner[j] = w;
                m_held[j]  = 1;
            end else begin
                m_owner[j] = -1;
            end
        end
        s = (m_owner[j] >= 0) ? m_owner[j] : m_last[j];
        m_last[j] = s;
        e.sel  = 4'(s);
        e.gnt  = '0;
        if (m_owner[j] >= 0) e.gnt[m_owner[j]] = 1'b1;
        e.busy = (m_owner[j] >= 0);
    endtask

    // Called just after a falling edge: drives req and queues the response
    // expected after the next rising edge.
    task automatic drive(input logic [0:15] r);
        exp_t e;
        req = r;
        model_step(0, r, e);
        q8.push_back(e);
        model_step(1, r, e);
        q2.push_back(e);
    endtask

    task automatic cycles(input logic [0:15] r, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(r);
        end
    endtask

    // Monitor: every rising edge out of reset the DUTs present a response.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                #1;
                if (q8.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb8_empty: got response with no expectation at %0t", $time);
                end else begin
                    e = q8.pop_front();
                    chk("sel8",  32'(sel8),  32'(e.sel));
                    chk("gnt8",  32'(gnt8),  32'(e.gnt));
                    chk("busy8", 32'(busy8), 32'(e.busy));
                end
                if (q2.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb2_empty: got response with no expectation at %0t", $time);
                end else begin
                    e = q2.pop_front();
                    chk("sel2",  32'(sel2),  32'(e.sel));
                    chk("gnt2",  32'(gnt2),  32'(e.gnt));
                    chk("busy2", 32'(busy2), 32'(e.busy));
                end
            end
        end
    end

    initial begin
        logic [0:15] r;

        // Reset with every request high: outputs must stay cleared.
        rst_n = 1'b0;
        req   = 16'hFFFF;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_sel8",  32'(sel8),  32'd0);
        chk("rst_gnt8",  32'(gnt8),  32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_gnt2",  32'(gnt2),  32'd0);
        chk("rst_busy2", 32'(busy2), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h0000);
        cycles(16'h0000, 3);

        // Single requester 5 for three cycles, then drop.
        cycles(16'b0000_0100_0000_0000, 3);
        cycles(16'h0000, 3);

        // Everyone requesting: full rotation with back-to-back handoff.
        cycles(16'hFFFF, 16 * 8 + 12);
        cycles(16'h0000, 2);

        // Wrap and fairness: owner 15 drops with 0 and 14 pending, then 0 drops.
        r = '0; r[15] = 1'b1;
        cycles(r, 2);
        r = '0; r[0] = 1'b1; r[14] = 1'b1;
        cycles(r, 1);
        r = '0; r[14] = 1'b1; r[15] = 1'b1;
        cycles(r, 3);
        cycles(16'h0000, 2);

        // Sole requester 3: timeout must regrant it immediately.
        r = '0; r[3] = 1'b1;
        cycles(r, 12);

        // Reset asserted mid-grant clears outputs before the next edge.
        r = '0; r[9] = 1'b1;
        cycles(r, 3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_gnt8",  32'(gnt8),  32'd0);
        chk("arst_busy8", 32'(busy8), 32'd0);
        chk("arst_sel8",  32'(sel8),  32'd0);
        chk("arst_gnt2",  32'(gnt2),  32'd0);
        chk("arst_busy2", 32'(busy2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(r);

        // Randomised requests that mostly persist, so timeouts and rotation mix.
        r = '0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(7) == 0) r[i] = ~r[i];
            end
            if ($urandom_range(40) == 0) r = '0;
            @(negedge clk);
            drive(r);
        end

        @(posedge clk);
        #2;
        chk("sb8_drained", 32'(q8.size()), 32'd0);
        chk("sb2_drained", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
